// File: rtl/mlaccel_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mlaccel_sequencer
// Brief    : Byte-stream command sequencer that loads mlaccel_compute code
//            memory and launches execution runs through its ctrl_* port.
// Revision : 1.0 - initial release
// ============================================================================
module mlaccel_sequencer #(
  parameter int N = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [10:0]      ctrl_addr,
  output logic [10:0]      ctrl_execute,
  input  logic             ctrl_busy,
  output logic [N-1:0]     ctrl_wen_coeff,
  output logic             ctrl_wen_opcode,
  output logic [8*N-1:0]   ctrl_wdata_coeff,
  output logic [31:0]      ctrl_wdata_opcode,
  output logic             err
);

  localparam int c_NARG = 4 + N;
  localparam int c_CW   = $clog2(c_NARG + 1);
  localparam int c_SW   = 8 * (c_NARG - 1);

  localparam logic [7:0] c_CMD_NOP     = 8'h00;
  localparam logic [7:0] c_CMD_SETADDR = 8'h01;
  localparam logic [7:0] c_CMD_WRITE   = 8'h02;
  localparam logic [7:0] c_CMD_EXEC    = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARG    = 3'd1,
    S_WPULSE = 3'd2,
    S_XWAIT  = 3'd3,
    S_XPULSE = 3'd4,
    S_XHOLD  = 3'd5,
    S_XDRAIN = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    K_SETADDR = 2'd0,
    K_WRITE   = 2'd1,
    K_EXEC    = 2'd2
  } kind_t;

  state_t            r_state;
  kind_t             r_kind;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   r_last;
  logic [c_SW-1:0]   r_args;
  logic [10:0]       r_count;
  logic              r_in_ready;
  logic [10:0]       r_addr;
  logic [10:0]       r_execute;
  logic [N-1:0]      r_wen_coeff;
  logic              r_wen_opcode;
  logic [8*N-1:0]    r_wdata_coeff;
  logic [31:0]       r_wdata_opcode;
  logic              r_err;

  logic              w_xfer;
  logic [8*c_NARG-1:0] w_full;
  logic [10:0]       w_arg2;

  // Argument bytes shift in from the top, so after the final byte the whole
  // payload sits little-endian with byte 0 in the least significant lane.
  assign w_xfer = in_valid && r_in_ready;
  assign w_full = {in_data, r_args};
  assign w_arg2 = {in_data[2:0], r_args[c_SW-1 -: 8]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_kind         <= K_SETADDR;
      r_cnt          <= '0;
      r_last         <= '0;
      r_args         <= '0;
      r_count        <= '0;
      r_in_ready     <= 1'b0;
      r_addr         <= '0;
      r_execute      <= '0;
      r_wen_coeff    <= '0;
      r_wen_opcode   <= 1'b0;
      r_wdata_coeff  <= '0;
      r_wdata_opcode <= '0;
      r_err          <= 1'b0;
    end else begin
      r_execute    <= '0;
      r_wen_coeff  <= '0;
      r_wen_opcode <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_cnt <= '0;
            case (in_data)
              c_CMD_NOP: ;
              c_CMD_SETADDR: begin
                r_kind  <= K_SETADDR;
                r_last  <= c_CW'(1);
                r_state <= S_ARG;
              end
              c_CMD_WRITE: begin
                r_kind  <= K_WRITE;
                r_last  <= c_CW'(c_NARG - 1);
                r_state <= S_ARG;
              end
              c_CMD_EXEC: begin
                r_kind  <= K_EXEC;
                r_last  <= c_CW'(1);
                r_state <= S_ARG;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        S_ARG: begin
          if (w_xfer) begin
            r_args <= {in_data, r_args[c_SW-1:8]};
            r_cnt  <= r_cnt + c_CW'(1);
            if (r_cnt == r_last) begin
              r_cnt <= '0;
              case (r_kind)
                K_SETADDR: begin
                  r_addr  <= w_arg2;
                  r_state <= S_IDLE;
                end
                K_WRITE: begin
                  r_wdata_opcode <= w_full[31:0];
                  r_wdata_coeff  <= w_full[8*c_NARG-1:32];
                  r_wen_opcode   <= 1'b1;
                  r_wen_coeff    <= '1;
                  r_in_ready     <= 1'b0;
                  r_state        <= S_WPULSE;
                end
                default: begin
                  if (w_arg2 == 11'd0) begin
                    r_state <= S_IDLE;
                  end else begin
                    r_count    <= w_arg2;
                    r_in_ready <= 1'b0;
                    r_state    <= S_XWAIT;
                  end
                end
              endcase
            end
          end
        end
        S_WPULSE: begin
          r_addr     <= r_addr + 11'd1;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_XWAIT: begin
          if (!ctrl_busy) begin
            r_execute <= r_count;
            r_state   <= S_XPULSE;
          end
        end
        S_XPULSE: r_state <= S_XHOLD;
        // Compute raises busy during XHOLD, so busy is only sampled from XDRAIN on.
        S_XHOLD:  r_state <= S_XDRAIN;
        S_XDRAIN: begin
          if (!ctrl_busy) begin
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready          = r_in_ready;
  assign ctrl_addr         = r_addr;
  assign ctrl_execute      = r_execute;
  assign ctrl_wen_coeff    = r_wen_coeff;
  assign ctrl_wen_opcode   = r_wen_opcode;
  assign ctrl_wdata_coeff  = r_wdata_coeff;
  assign ctrl_wdata_opcode = r_wdata_opcode;
  assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mlaccel_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mlaccel_sequencer
// Brief    : Directed plus randomized command streams against a
//            transaction-level model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlaccel_sequencer;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic [10:0]     ctrl_addr;
  logic [10:0]     ctrl_execute;
  logic            ctrl_busy;
  logic [N-1:0]    ctrl_wen_coeff;
  logic            ctrl_wen_opcode;
  logic [8*N-1:0]  ctrl_wdata_coeff;
  logic [31:0]     ctrl_wdata_opcode;
  logic            err;

  mlaccel_sequencer #(.N(N)) u_dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .ctrl_addr         (ctrl_addr),
    .ctrl_execute      (ctrl_execute),
    .ctrl_busy         (ctrl_busy),
    .ctrl_wen_coeff    (ctrl_wen_coeff),
    .ctrl_wen_opcode   (ctrl_wen_opcode),
    .ctrl_wdata_coeff  (ctrl_wdata_coeff),
    .ctrl_wdata_opcode (ctrl_wdata_opcode),
    .err               (err)
  );

  initial forever #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [10:0] addr; logic [31:0] op; logic [8*N-1:0] co; } wr_t;
  typedef struct { logic [10:0] addr; logic [10:0] cnt; } ex_t;

  wr_t obs_wr[$];
  wr_t exp_wr[$];
  ex_t obs_ex[$];
  ex_t exp_ex[$];

  // Compute-side busy: rises the cycle after a launch pulse, lasts busy_len cycles.
  logic busy_run   = 1'b0;
  logic busy_force = 1'b0;
  logic busy_pend  = 1'b0;
  int   busy_len   = 4;
  int   busy_rem   = 0;
  assign ctrl_busy = busy_run | busy_force;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (busy_rem > 0) begin
        busy_rem--;
        if (busy_rem == 0) busy_run = 1'b0;
      end
      if (busy_pend) begin
        busy_pend = 1'b0;
        busy_run  = 1'b1;
        busy_rem  = busy_len;
      end
      if (ctrl_execute != 11'd0) busy_pend = 1'b1;
    end
  end

  logic prev_x = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (ctrl_wen_opcode || (ctrl_wen_coeff != '0)) begin
          check_eq("wen_both", {ctrl_wen_opcode, ctrl_wen_coeff}, {1'b1, {N{1'b1}}});
          obs_wr.push_back('{ctrl_addr, ctrl_wdata_opcode, ctrl_wdata_coeff});
        end
        if (ctrl_execute != 11'd0) begin
          check_eq("x_1cyc", prev_x, 0);
          obs_ex.push_back('{ctrl_addr, ctrl_execute});
        end
      end
      prev_x = (ctrl_execute != 11'd0);
    end
  end

  // Transaction-level reference state
  logic [10:0] m_addr;
  logic        m_err;
  logic [7:0]  cmdq[$];

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) check_eq("rdy_timeout", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic model_apply();
    logic [8*N-1:0] co;
    logic [10:0]    cnt;
    case (cmdq[0])
      8'h00: ;
      8'h01: m_addr = {cmdq[2][2:0], cmdq[1]};
      8'h02: begin
        for (int k = 0; k < N; k++) co[8*k +: 8] = cmdq[5+k];
        exp_wr.push_back('{m_addr, {cmdq[4], cmdq[3], cmdq[2], cmdq[1]}, co});
        m_addr = m_addr + 11'd1;
      end
      8'h03: begin
        cnt = {cmdq[2][2:0], cmdq[1]};
        if (cnt != 11'd0) exp_ex.push_back('{m_addr, cnt});
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) check_eq("settle_timeout", in_ready, 1);
    @(negedge clock);
  endtask

  task automatic check_results();
    wr_t o;
    wr_t e;
    ex_t ox;
    ex_t ex;
    check_eq("n_write", obs_wr.size(), exp_wr.size());
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      o = obs_wr.pop_front();
      e = exp_wr.pop_front();
      check_eq("wr_addr", o.addr, e.addr);
      check_eq("wr_opcode", o.op, e.op);
      check_eq("wr_coeff", o.co, e.co);
    end
    check_eq("n_exec", obs_ex.size(), exp_ex.size());
    while (obs_ex.size() > 0 && exp_ex.size() > 0) begin
      ox = obs_ex.pop_front();
      ex = exp_ex.pop_front();
      check_eq("ex_addr", ox.addr, ex.addr);
      check_eq("ex_count", ox.cnt, ex.cnt);
    end
    obs_wr.delete(); exp_wr.delete(); obs_ex.delete(); exp_ex.delete();
    check_eq("ctrl_addr", ctrl_addr, m_addr);
    check_eq("err", err, m_err);
  endtask

  task automatic run_cmd();
    foreach (cmdq[i]) send(cmdq[i]);
    model_apply();
    settle();
    check_results();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {in_ready, ctrl_addr, ctrl_execute, ctrl_wen_opcode, ctrl_wen_coeff, err}, 0);
    check_eq({tag, "_wop"}, ctrl_wdata_opcode, 0);
    check_eq({tag, "_wco"}, ctrl_wdata_coeff, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    #2;
    check_reset_outputs("rst_async");
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    m_addr = '0;
    m_err  = 1'b0;
    obs_wr.delete(); exp_wr.delete(); obs_ex.delete(); exp_ex.delete();
  endtask

  task automatic rand_write();
    cmdq = {8'h02};
    for (int k = 0; k < 4 + N; k++) cmdq.push_back(8'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int r;
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    m_addr   = '0;
    m_err    = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst_init");
    reset = 1'b0;

    // Reset in the middle of a WRITE discards the partial payload
    send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    do_reset();
    cmdq = {8'h00};             run_cmd();
    cmdq = {8'h01, 8'h05, 8'h00}; run_cmd();

    // Write at the top address, address wraps to 0
    cmdq = {8'h01, 8'hFF, 8'h07}; run_cmd();
    cmdq = {8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd();
    check_eq("wrap_addr", ctrl_addr, 11'd0);

    // Back-to-back writes from address 10
    cmdq = {8'h01, 8'h0A, 8'hF8}; run_cmd();
    rand_write(); run_cmd();
    rand_write(); run_cmd();
    check_eq("b2b_addr", ctrl_addr, 11'd12);

    // EXEC issued while compute is busy
    busy_force = 1'b1;
    busy_len   = 20;
    cmdq = {8'h03, 8'h03, 8'h00};
    foreach (cmdq[i]) send(cmdq[i]);
    model_apply();
    repeat (10) begin
      check_eq("xwait_rdy", in_ready, 0);
      @(negedge clock);
    end
    check_eq("xwait_nopulse", obs_ex.size(), 0);
    busy_force = 1'b0;
    n = 0;
    while (obs_ex.size() == 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (!in_ready && n < 200) begin
      if (ctrl_busy) check_eq("drain_rdy", in_ready, 0);
      @(negedge clock);
      n++;
    end
    check_eq("drain_done_busy", ctrl_busy, 0);
    @(negedge clock);
    check_results();

    // EXEC with zero count is dropped
    send(8'h03); send(8'h00); send(8'h00);
    check_eq("x0_rdy", in_ready, 1);
    cmdq = {8'h03, 8'h00, 8'h00};
    model_apply();
    @(negedge clock);
    check_results();

    // Unknown command sets the sticky error
    cmdq = {8'h7F};               run_cmd();
    cmdq = {8'h01, 8'h02, 8'h00}; run_cmd();

    // Randomized command mix
    for (int t = 0; t < 150; t++) begin
      busy_len = $urandom_range(1, 10);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        cmdq = {8'h00};
      end else if (r <= 4) begin
        cmdq = {8'h01, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom)};
      end else if (r <= 12) begin
        rand_write();
      end else if (r <= 18) begin
        if ($urandom_range(0, 4) == 0)
          cmdq = {8'h03, 8'h00, {5'($urandom), 3'b000}};
        else
          cmdq = {8'h03, 8'($urandom), 8'($urandom)};
      end else begin
        cmdq = {8'($urandom_range(4, 255))};
      end
      run_cmd();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
